input_conditioner: RTL and testbench

- Parametrised front-end for all board inputs: NUM_KEYS push-buttons and a DATA_W-bit switch bank.
- Every input is synchronised into CLK_50MHz.
- Each key is debounced and yields a stable level plus a one-cycle press pulse.
- The switch word is gated onto the processor databus by Extrn_Enable, either live or as a key-captured snapshot. Sits between the board I/O pins and the processor bus/controller.

---
 rtl/input_pkg.sv | 15 +
 rtl/key_debounce_channel.sv | 73 +++++++
 rtl/input_conditioner.sv | 94 +++++++++
 tb/tb_input_conditioner.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// Shared constants and types for the board input front-end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package input_pkg;

    localparam int DEFAULT_DEBOUNCE_50MHZ = 1000000;
    localparam int KEY_PEEK               = 0;
    localparam int KEY_CLK                = 1;

    typedef enum logic {
        DATA_LIVE     = 1'b0,
        DATA_SNAPSHOT = 1'b1
    } data_mode_e;

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-FF synchroniser, polarity fix, stable-count debounce, press/release pulses.
// Latency: pin edge to level change is 2 + DEBOUNCE_CYCLES cycles; pulses coincide with the level change.
// Backpressure: none; pulses are single-cycle and never repeat while the key is held.
module key_debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw_key,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic [CNT_W-1:0] r_cnt;

    logic w_key;
    logic w_differs;
    logic w_accept;

    // Two-flop synchroniser; reset loads the idle pin level so a held key is re-qualified after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync0 <= ACTIVE_LOW;
            r_sync1 <= ACTIVE_LOW;
        end else begin
            r_sync0 <= i_raw_key;
            r_sync1 <= r_sync0;
        end
    end

    assign w_key     = r_sync1 ^ ACTIVE_LOW;
    assign w_differs = (w_key != r_level);
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);

    // Count consecutive cycles the synced key disagrees with the level; any agreement restarts it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!w_differs || w_accept) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Accept the new level and emit a one-cycle pulse in the direction of the change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_level   <= r_level ^ w_accept;
            r_press   <= w_accept & ~r_level;
            r_release <= w_accept & r_level;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/input_conditioner.sv
// Board input front-end: debounced keys with pulses, synchronised switches gated onto the databus.
// Latency: keys 2 + DEBOUNCE_CYCLES cycles; switch data 2 cycles, Extrn_Enable gating is combinational.
// Backpressure: none; databus is driven whenever Extrn_Enable is high, otherwise all-zero.
module input_conditioner
    import input_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DATA_W          = 10,
    parameter int LOW_W           = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_50MHZ,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int DATA_MODE       = 0,
    parameter int LATCH_KEY       = KEY_PEEK
) (
    input  logic                CLK_50MHz,
    input  logic                Reset_n,
    input  logic [NUM_KEYS-1:0] RawKeys,
    input  logic [DATA_W-1:0]   RawData,
    input  logic                Extrn_Enable,
    output logic [NUM_KEYS-1:0] Key_level,
    output logic [NUM_KEYS-1:0] Key_press,
    output logic [NUM_KEYS-1:0] Key_release,
    output logic [DATA_W-1:0]   databus,
    output logic [LOW_W-1:0]    Data_low,
    output logic                Snap_valid
);

    localparam bit SNAP_EN = (DATA_MODE == int'(DATA_SNAPSHOT));

    if (LOW_W > DATA_W) begin : g_chk_low_w
        $error("input_conditioner: LOW_W must not exceed DATA_W");
    end
    if (LATCH_KEY >= NUM_KEYS) begin : g_chk_latch_key
        $error("input_conditioner: LATCH_KEY must index an existing key");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [DATA_W-1:0] r_data_sync0;
    logic [DATA_W-1:0] r_data_sync1;
    logic [DATA_W-1:0] w_ext_data;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (KEY_ACTIVE_LOW != 0)
        ) u_chan (
            .i_clk     (CLK_50MHz),
            .i_rst_n   (Reset_n),
            .i_raw_key (RawKeys[gi]),
            .o_level   (Key_level[gi]),
            .o_press   (Key_press[gi]),
            .o_release (Key_release[gi])
        );
    end

    // Two-flop synchroniser on every switch bit.
    always_ff @(posedge CLK_50MHz or negedge Reset_n) begin
        if (!Reset_n) begin
            r_data_sync0 <= '0;
            r_data_sync1 <= '0;
        end else begin
            r_data_sync0 <= RawData;
            r_data_sync1 <= r_data_sync0;
        end
    end

    if (SNAP_EN) begin : g_snap
        logic [DATA_W-1:0] r_snapshot;
        logic              r_snap_valid;

        // Capture the synced switches while the latch key's press pulse is high; later presses overwrite.
        always_ff @(posedge CLK_50MHz or negedge Reset_n) begin
            if (!Reset_n) begin
                r_snapshot   <= '0;
                r_snap_valid <= 1'b0;
            end else if (Key_press[LATCH_KEY]) begin
                r_snapshot   <= r_data_sync1;
                r_snap_valid <= 1'b1;
            end
        end

        assign w_ext_data = r_snapshot;
        assign Snap_valid = r_snap_valid;
    end else begin : g_live
        assign w_ext_data = r_data_sync1;
        assign Snap_valid = 1'b0;
    end

    assign databus  = Extrn_Enable ? w_ext_data : '0;
    assign Data_low = r_data_sync1[LOW_W-1:0];

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: one live-mode and one snapshot-mode instance share all stimulus.
// Expected values come from constant tables, hand sequences and a sample-history model.
module tb_input_conditioner;

    localparam int NK = 2;
    localparam int DW = 10;
    localparam int LW = 2;
    localparam int DB = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] keys  = '1;
    logic [DW-1:0] data  = '1;
    logic          en    = 1'b0;

    logic [NK-1:0] lvl0, prs0, rel0, lvl1, prs1, rel1;
    logic [DW-1:0] bus0, bus1;
    logic [LW-1:0] low0, low1;
    logic          sv0, sv1;

    always #10 clk = ~clk;

    input_conditioner #(
        .NUM_KEYS(NK), .DATA_W(DW), .LOW_W(LW), .DEBOUNCE_CYCLES(DB),
        .KEY_ACTIVE_LOW(1), .DATA_MODE(0), .LATCH_KEY(0)
    ) dut0 (
        .CLK_50MHz(clk), .Reset_n(rst_n), .RawKeys(keys), .RawData(data),
        .Extrn_Enable(en), .Key_level(lvl0), .Key_press(prs0), .Key_release(rel0),
        .databus(bus0), .Data_low(low0), .Snap_valid(sv0)
    );

    input_conditioner #(
        .NUM_KEYS(NK), .DATA_W(DW), .LOW_W(LW), .DEBOUNCE_CYCLES(DB),
        .KEY_ACTIVE_LOW(1), .DATA_MODE(1), .LATCH_KEY(0)
    ) dut1 (
        .CLK_50MHz(clk), .Reset_n(rst_n), .RawKeys(keys), .RawData(data),
        .Extrn_Enable(en), .Key_level(lvl1), .Key_press(prs1), .Key_release(rel1),
        .databus(bus1), .Data_low(low1), .Snap_valid(sv1)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: per-key history of pressed samples (bit 0 newest), data history, snapshot.
    logic [7:0]    kh [NK];
    logic [NK-1:0] m_level, m_press, m_rel;
    logic [DW-1:0] dh0, dh1, dh2;
    logic [DW-1:0] m_snap;
    logic          m_snapv;

    typedef struct {
        logic [NK-1:0] keys;
        logic [DW-1:0] data;
        logic          en;
        int            ncyc;
        logic [NK-1:0] lvl;
        logic [NK-1:0] prs;
        logic [NK-1:0] rel;
        logic [DW-1:0] b0;
        logic [DW-1:0] b1;
        logic [LW-1:0] low;
        logic          sv;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) kh[k] = '0;
        m_level = '0; m_press = '0; m_rel = '0;
        dh0 = '0; dh1 = '0; dh2 = '0;
        m_snap = '0; m_snapv = 1'b0;
    endtask

    // A key flips once the synced samples of the last DB edges all disagree with its level.
    task automatic model_edge();
        logic [NK-1:0] prev_press;
        bit            all_diff;
        prev_press = m_press;
        m_press = '0;
        m_rel   = '0;
        for (int k = 0; k < NK; k++) begin
            kh[k] = {kh[k][6:0], ~keys[k]};
            all_diff = 1'b1;
            for (int j = 2; j < DB + 2; j++)
                if (kh[k][j] == m_level[k]) all_diff = 1'b0;
            if (all_diff) begin
                if (m_level[k]) m_rel[k] = 1'b1;
                else            m_press[k] = 1'b1;
                m_level[k] = ~m_level[k];
            end
        end
        dh2 = dh1; dh1 = dh0; dh0 = data;
        if (prev_press[0]) begin
            m_snap  = dh2;
            m_snapv = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("level0",  32'(lvl0), 32'(m_level));
        chk("press0",  32'(prs0), 32'(m_press));
        chk("rel0",    32'(rel0), 32'(m_rel));
        chk("level1",  32'(lvl1), 32'(m_level));
        chk("press1",  32'(prs1), 32'(m_press));
        chk("rel1",    32'(rel1), 32'(m_rel));
        chk("bus_live", 32'(bus0), en ? 32'(dh1) : 32'd0);
        chk("bus_snap", 32'(bus1), en ? 32'(m_snap) : 32'd0);
        chk("low0",    32'(low0), 32'(dh1[LW-1:0]));
        chk("low1",    32'(low1), 32'(dh1[LW-1:0]));
        chk("snapv0",  32'(sv0), 32'd0);
        chk("snapv1",  32'(sv1), 32'(m_snapv));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int first;
    int npulse;
    int hold [NK];

    initial begin
        tbl[0]  = '{2'b11, 10'h3FF, 1'b0, 2, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 2'b11, 1'b0};
        tbl[1]  = '{2'b10, 10'h155, 1'b0, 5, 2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 2'b01, 1'b0};
        tbl[2]  = '{2'b10, 10'h155, 1'b0, 1, 2'b01, 2'b01, 2'b00, 10'h000, 10'h000, 2'b01, 1'b0};
        tbl[3]  = '{2'b10, 10'h155, 1'b0, 1, 2'b01, 2'b00, 2'b00, 10'h000, 10'h000, 2'b01, 1'b1};
        tbl[4]  = '{2'b10, 10'h0F0, 1'b1, 3, 2'b01, 2'b00, 2'b00, 10'h0F0, 10'h155, 2'b00, 1'b1};
        tbl[5]  = '{2'b10, 10'h0F0, 1'b0, 1, 2'b01, 2'b00, 2'b00, 10'h000, 10'h000, 2'b00, 1'b1};
        tbl[6]  = '{2'b11, 10'h0F0, 1'b1, 5, 2'b01, 2'b00, 2'b00, 10'h0F0, 10'h155, 2'b00, 1'b1};
        tbl[7]  = '{2'b11, 10'h0F0, 1'b1, 1, 2'b00, 2'b00, 2'b01, 10'h0F0, 10'h155, 2'b00, 1'b1};
        tbl[8]  = '{2'b11, 10'h0F0, 1'b1, 1, 2'b00, 2'b00, 2'b00, 10'h0F0, 10'h155, 2'b00, 1'b1};
        tbl[9]  = '{2'b10, 10'h0F0, 1'b1, 6, 2'b01, 2'b01, 2'b00, 10'h0F0, 10'h155, 2'b00, 1'b1};
        tbl[10] = '{2'b10, 10'h0F0, 1'b1, 1, 2'b01, 2'b00, 2'b00, 10'h0F0, 10'h0F0, 2'b00, 1'b1};
        tbl[11] = '{2'b10, 10'h2A5, 1'b1, 1, 2'b01, 2'b00, 2'b00, 10'h0F0, 10'h0F0, 2'b00, 1'b1};
        tbl[12] = '{2'b10, 10'h2A5, 1'b1, 1, 2'b01, 2'b00, 2'b00, 10'h2A5, 10'h0F0, 2'b01, 1'b1};
        tbl[13] = '{2'b10, 10'h2A5, 1'b0, 0, 2'b01, 2'b00, 2'b00, 10'h000, 10'h000, 2'b01, 1'b1};

        // Power-on reset with idle inputs.
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Directed vector table.
        for (int v = 0; v < 14; v++) begin
            keys = tbl[v].keys;
            data = tbl[v].data;
            en   = tbl[v].en;
            if (tbl[v].ncyc == 0) begin
                #1;
                compare_all();
            end else begin
                repeat (tbl[v].ncyc) step();
            end
            chk($sformatf("vec%0d.level", v), 32'(lvl0), 32'(tbl[v].lvl));
            chk($sformatf("vec%0d.press", v), 32'(prs1), 32'(tbl[v].prs));
            chk($sformatf("vec%0d.rel", v),   32'(rel0), 32'(tbl[v].rel));
            chk($sformatf("vec%0d.bus0", v),  32'(bus0), 32'(tbl[v].b0));
            chk($sformatf("vec%0d.bus1", v),  32'(bus1), 32'(tbl[v].b1));
            chk($sformatf("vec%0d.low", v),   32'(low0), 32'(tbl[v].low));
            chk($sformatf("vec%0d.snapv", v), 32'(sv1),  32'(tbl[v].sv));
        end

        // Key 1 bounces every 2 cycles for 20 cycles, then holds pressed.
        npulse = 0;
        for (int c = 0; c < 20; c++) begin
            keys[1] = ((c / 2) % 2) != 0;
            step();
            if (prs0[1]) npulse++;
        end
        chk("bounce_quiet", 32'(npulse), 32'd0);
        keys[1] = 1'b0;
        first = 0;
        npulse = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (prs0[1]) begin
                npulse++;
                if (first == 0) first = c;
            end
        end
        chk("bounce_press_cycle", 32'(first), 32'd6);
        chk("bounce_press_count", 32'(npulse), 32'd1);

        // Reset arrives two counts into a held press; the press must requalify from scratch.
        keys = 2'b11;
        repeat (10) step();
        keys = 2'b10;
        en = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_level", 32'(lvl0), 32'd0);
        chk("rst_press", 32'(prs0), 32'd0);
        chk("rst_bus0",  32'(bus0), 32'd0);
        chk("rst_bus1",  32'(bus1), 32'd0);
        chk("rst_low",   32'(low0), 32'd0);
        chk("rst_snapv", 32'(sv1),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        first = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (prs0[0] && first == 0) first = c;
        end
        chk("rst_press_cycle", 32'(first), 32'd6);

        // Random keys with varied hold times, random data/enable, occasional reset.
        for (int k = 0; k < NK; k++) hold[k] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (hold[k] == 0) begin
                    keys[k] = 1'($urandom_range(0, 1));
                    hold[k] = $urandom_range(1, 8);
                end
                hold[k]--;
            end
            if ($urandom_range(0, 2) == 0) data = DW'($urandom);
            en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) do_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
